// File: rtl/tgate_ctrl_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tgate_ctrl_seq_if : channel-select request handshake               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface tgate_ctrl_seq_if #(
  parameter int SELW = 2
);
  logic            req_valid;
  logic            req_ready;
  logic [SELW-1:0] req_sel;
  logic            req_off;

  modport master (output req_valid, output req_sel, output req_off, input  req_ready);
  modport slave  (input  req_valid, input  req_sel, input  req_off, output req_ready);
endinterface
`default_nettype wire

// File: rtl/tgate_ctrl_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tgate_ctrl_seq : break-before-make sequencer for a t-gate bank     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tgate_ctrl_seq #(
  parameter int NCH        = 4,
  parameter int SELW       = 2,
  parameter int DEAD_CYC   = 3,
  parameter int SETTLE_CYC = 2,
  parameter int CNTW       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  tgate_ctrl_seq_if.slave     req,
  output logic [NCH-1:0]      ncontrol,
  output logic [NCH-1:0]      pcontrol,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [SELW-1:0]     cur_sel,
  output logic                cur_on
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_break  = 3'd1;
  localparam logic [2:0] c_st_dead   = 3'd2;
  localparam logic [2:0] c_st_make   = 3'd3;
  localparam logic [2:0] c_st_settle = 3'd4;
  localparam logic [2:0] c_st_done   = 3'd5;

  // Reload values are only used when the matching cycle count is nonzero.
  localparam logic [CNTW-1:0] c_dead_ld   = CNTW'((DEAD_CYC   > 0) ? DEAD_CYC   - 1 : 0);
  localparam logic [CNTW-1:0] c_settle_ld = CNTW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  logic [2:0]      r_state;
  logic [CNTW-1:0] r_timer;
  logic [SELW-1:0] r_sel;
  logic            r_off;
  logic [SELW-1:0] r_cur_sel;
  logic            r_cur_on;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [NCH-1:0]  r_ncontrol;
  logic [NCH-1:0]  r_pcontrol;

  logic            w_sel_bad;
  logic            w_match;
  logic            w_dead_exit;
  logic [NCH-1:0]  w_onehot;

  assign w_sel_bad   = (32'(req.req_sel) >= 32'(NCH));
  assign w_match     = (!req.req_off && r_cur_on && (req.req_sel == r_cur_sel)) ||
                       ( req.req_off && !r_cur_on);
  assign w_onehot    = NCH'(1) << r_sel;
  assign w_dead_exit = (r_state == c_st_dead) ? (r_timer == '0) : (DEAD_CYC == 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_timer    <= '0;
      r_sel      <= '0;
      r_off      <= 1'b0;
      r_cur_sel  <= '0;
      r_cur_on   <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ncontrol <= '0;
      r_pcontrol <= '1;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (req.req_valid && r_ready) begin
            if (!req.req_off && w_sel_bad) begin
              r_err <= 1'b1;
            end else if (w_match) begin
              r_state <= c_st_done;
              r_done  <= 1'b1;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end else begin
              // Break happens on the accept edge itself.
              r_state    <= c_st_break;
              r_ncontrol <= '0;
              r_pcontrol <= '1;
              r_cur_on   <= 1'b0;
              r_sel      <= req.req_sel;
              r_off      <= req.req_off;
              r_ready    <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        c_st_break, c_st_dead: begin
          if (w_dead_exit) begin
            if (r_off) begin
              r_state <= c_st_done;
              r_done  <= 1'b1;
            end else begin
              r_state    <= c_st_make;
              r_ncontrol <= w_onehot;
              r_pcontrol <= ~w_onehot;
              r_cur_sel  <= r_sel;
              r_cur_on   <= 1'b1;
            end
          end else if (r_state == c_st_break) begin
            r_state <= c_st_dead;
            r_timer <= c_dead_ld;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        c_st_make: begin
          if (SETTLE_CYC == 0) begin
            r_state <= c_st_done;
            r_done  <= 1'b1;
          end else begin
            r_state <= c_st_settle;
            r_timer <= c_settle_ld;
          end
        end
        c_st_settle: begin
          if (r_timer == '0) begin
            r_state <= c_st_done;
            r_done  <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        c_st_done: begin
          r_state <= c_st_idle;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= c_st_idle;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req.req_ready = r_ready;
  assign ncontrol      = r_ncontrol;
  assign pcontrol      = r_pcontrol;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign cur_sel       = r_cur_sel;
  assign cur_on        = r_cur_on;

endmodule
`default_nettype wire

// File: tb/tb_tgate_ctrl_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tgate_ctrl_seq : directed bench, default build and 0/0 build    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_tgate_ctrl_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Main build: SELW=3 so out-of-range selects can be presented.
  tgate_ctrl_seq_if #(.SELW(3)) m_if ();
  logic [3:0] m_ncontrol, m_pcontrol;
  logic       m_busy, m_done, m_err, m_cur_on;
  logic [2:0] m_cur_sel;

  tgate_ctrl_seq #(.NCH(4), .SELW(3), .DEAD_CYC(3), .SETTLE_CYC(2), .CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(m_if.slave),
    .ncontrol(m_ncontrol), .pcontrol(m_pcontrol), .busy(m_busy), .done(m_done),
    .err(m_err), .cur_sel(m_cur_sel), .cur_on(m_cur_on)
  );

  tgate_ctrl_seq_if #(.SELW(2)) z_if ();
  logic [3:0] z_ncontrol, z_pcontrol;
  logic       z_busy, z_done, z_err, z_cur_on;
  logic [1:0] z_cur_sel;

  tgate_ctrl_seq #(.NCH(4), .SELW(2), .DEAD_CYC(0), .SETTLE_CYC(0), .CNTW(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(z_if.slave),
    .ncontrol(z_ncontrol), .pcontrol(z_pcontrol), .busy(z_busy), .done(z_done),
    .err(z_err), .cur_sel(z_cur_sel), .cur_on(z_cur_on)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_req(input int sel, input bit off);
    m_if.req_valid = 1'b1;
    m_if.req_sel   = 3'(sel);
    m_if.req_off   = off;
    tick();
    m_if.req_valid = 1'b0;
  endtask

  task automatic z_req(input int sel, input bit off);
    z_if.req_valid = 1'b1;
    z_if.req_sel   = 2'(sel);
    z_if.req_off   = off;
    tick();
    z_if.req_valid = 1'b0;
  endtask

  // DEAD=3, SETTLE=2: gates off k=0..3, made at k=4, done at k=7, ready at k=8.
  task automatic run_switch(input string tag, input int sel, input logic [3:0] n_new);
    m_req(sel, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      chk($sformatf("%s_ncontrol_k%0d", tag, k), m_ncontrol, (k < 4) ? 4'b0000 : n_new);
      chk($sformatf("%s_done_k%0d", tag, k), m_done, (k == 7));
      chk($sformatf("%s_ready_k%0d", tag, k), m_if.req_ready, (k == 8));
      chk($sformatf("%s_busy_k%0d", tag, k), m_busy, (k < 8));
      if (k == 4) begin
        chk($sformatf("%s_pcontrol_k4", tag), m_pcontrol, 4'(~n_new));
        chk($sformatf("%s_cur_sel_k4", tag), m_cur_sel, sel);
        chk($sformatf("%s_cur_on_k4", tag), m_cur_on, 1);
      end
      if (k < 8) tick();
    end
  endtask

  // Off request: all off from k=0, done at k=1+DEAD=4, ready at k=5.
  task automatic run_off(input string tag);
    m_req(0, 1'b1);
    for (int k = 0; k <= 5; k++) begin
      chk($sformatf("%s_ncontrol_k%0d", tag, k), m_ncontrol, 0);
      chk($sformatf("%s_done_k%0d", tag, k), m_done, (k == 4));
      chk($sformatf("%s_ready_k%0d", tag, k), m_if.req_ready, (k == 5));
      chk($sformatf("%s_cur_on_k%0d", tag, k), m_cur_on, 0);
      if (k < 5) tick();
    end
  endtask

  logic [3:0] m_prev = 4'b0;
  logic [3:0] z_prev = 4'b0;
  always @(negedge clk) begin
    chk("m_inv_pc", m_pcontrol, 4'(~m_ncontrol));
    chk("m_inv_pop", ($countones(m_ncontrol) <= 1), 1);
    chk("m_inv_bbm", (m_prev != 0) && (m_ncontrol != 0) && (m_ncontrol != m_prev), 0);
    m_prev = m_ncontrol;
    chk("z_inv_pc", z_pcontrol, 4'(~z_ncontrol));
    chk("z_inv_pop", ($countones(z_ncontrol) <= 1), 1);
    chk("z_inv_bbm", (z_prev != 0) && (z_ncontrol != 0) && (z_ncontrol != z_prev), 0);
    z_prev = z_ncontrol;
  end

  initial begin
    m_if.req_valid = 1'b0; m_if.req_sel = 3'd0; m_if.req_off = 1'b0;
    z_if.req_valid = 1'b0; z_if.req_sel = 2'd0; z_if.req_off = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    chk("rst_ncontrol", m_ncontrol, 0);
    chk("rst_pcontrol", m_pcontrol, 4'hF);
    chk("rst_ready", m_if.req_ready, 1);
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_err", m_err, 0);
    chk("rst_cur_on", m_cur_on, 0);
    chk("rst_cur_sel", m_cur_sel, 0);
    chk("rst_z_pcontrol", z_pcontrol, 4'hF);
    chk("rst_z_ready", z_if.req_ready, 1);

    run_switch("ch2", 2, 4'b0100);
    run_switch("ch2to0", 0, 4'b0001);

    // Same channel again: straight to done, gates untouched.
    m_req(0, 1'b0);
    chk("same_done", m_done, 1);
    chk("same_busy", m_busy, 1);
    chk("same_ncontrol", m_ncontrol, 4'b0001);
    chk("same_ready", m_if.req_ready, 0);
    tick();
    chk("same_done_end", m_done, 0);
    chk("same_busy_end", m_busy, 0);
    chk("same_ready_end", m_if.req_ready, 1);
    chk("same_ncontrol_end", m_ncontrol, 4'b0001);

    m_req(5, 1'b0);
    chk("err5_err", m_err, 1);
    chk("err5_done", m_done, 0);
    chk("err5_ready", m_if.req_ready, 1);
    chk("err5_busy", m_busy, 0);
    chk("err5_ncontrol", m_ncontrol, 4'b0001);
    tick();
    chk("err5_err_end", m_err, 0);
    chk("err5_ncontrol_end", m_ncontrol, 4'b0001);
    chk("err5_cur_sel", m_cur_sel, 0);

    m_req(4, 1'b0);
    chk("err4_err", m_err, 1);
    chk("err4_done", m_done, 0);
    tick();

    run_off("off");

    // Off while already off is an immediate done.
    m_req(0, 1'b1);
    chk("offoff_done", m_done, 1);
    chk("offoff_err", m_err, 0);
    tick();
    chk("offoff_ready", m_if.req_ready, 1);

    // Reset landing in SETTLE of a ch3 request (k=5).
    m_req(3, 1'b0);
    repeat (5) tick();
    chk("rs_pre_ncontrol", m_ncontrol, 4'b1000);
    chk("rs_pre_busy", m_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async_ncontrol", m_ncontrol, 0);
    chk("rs_async_pcontrol", m_pcontrol, 4'hF);
    chk("rs_async_busy", m_busy, 0);
    chk("rs_async_ready", m_if.req_ready, 1);
    chk("rs_async_cur_on", m_cur_on, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rs_post_done_%0d", k), m_done, 0);
      chk($sformatf("rs_post_ready_%0d", k), m_if.req_ready, 1);
      chk($sformatf("rs_post_busy_%0d", k), m_busy, 0);
    end

    // DEAD=0, SETTLE=0 build.
    z_req(1, 1'b0);
    chk("z1_ncontrol_k0", z_ncontrol, 0);
    chk("z1_busy_k0", z_busy, 1);
    tick();
    chk("z1_ncontrol_k1", z_ncontrol, 4'b0010);
    tick();
    chk("z1_done_k2", z_done, 1);
    tick();
    chk("z1_done_k3", z_done, 0);
    chk("z1_ready_k3", z_if.req_ready, 1);

    z_req(2, 1'b0);
    z_if.req_sel = 2'd3;
    chk("z2_ncontrol_k0", z_ncontrol, 0);
    chk("z2_done_k0", z_done, 0);
    tick();
    chk("z2_ncontrol_k1", z_ncontrol, 4'b0100);
    chk("z2_cur_sel_k1", z_cur_sel, 2);
    chk("z2_done_k1", z_done, 0);
    tick();
    chk("z2_done_k2", z_done, 1);
    chk("z2_ncontrol_k2", z_ncontrol, 4'b0100);
    tick();
    chk("z2_ready_k3", z_if.req_ready, 1);
    chk("z2_done_k3", z_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
